// File: rtl/hermes_input_buffer.sv
// Hermes router input port: a first-word-fall-through flit FIFO plus the packet
// tracker that requests a route for each header and forwards header, size and payload.
module hermes_input_buffer #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 h_o,
    input  logic                 ack_h_i,
    output logic                 data_av_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 ack_i,
    output logic                 sender_o
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH   = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [FLIT_SIZE-1:0] REM_ONE = FLIT_SIZE'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HDR     = 3'd2,
        SIZE    = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [FLIT_SIZE-1:0] remaining_q, remaining_d;
    state_t               state_q, state_d;

    logic not_empty;
    logic wr_en;
    logic rd_en;

    always_comb begin
        not_empty = (count_q != '0);
        credit_o  = (count_q < DEPTH);
        wr_en     = rx_i & credit_o;
        data_o    = not_empty ? mem_q[rd_ptr_q] : '0;

        h_o       = 1'b0;
        data_av_o = 1'b0;
        sender_o  = 1'b0;
        case (state_q)
            REQ:     h_o = 1'b1;
            HDR: begin
                data_av_o = 1'b1;
                sender_o  = 1'b1;
            end
            SIZE, PAYLOAD: begin
                data_av_o = not_empty;
                sender_o  = 1'b1;
            end
            default: ;
        endcase
        rd_en = data_av_o & ack_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && rd_en) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Packet tracker: the size flit tells how many payload flits follow it.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (not_empty) state_d = REQ;
            end
            REQ: begin
                if (ack_h_i) state_d = HDR;
            end
            HDR: begin
                if (rd_en) state_d = SIZE;
            end
            SIZE: begin
                if (rd_en) begin
                    remaining_d = data_o;
                    state_d     = (data_o != '0) ? PAYLOAD : IDLE;
                end
            end
            PAYLOAD: begin
                if (rd_en) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - REM_ONE;
                    end
                    if (remaining_q <= REM_ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            state_q     <= IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            state_q     <= state_d;
        end
    end

    // Storage carries data only; stale entries are unreachable once count clears.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer (depth 4, 16-bit flits): reset, packet
// forwarding, full buffer, zero-size packet, concurrent read/write and mid-packet reset.
module tb_hermes_input_buffer;

    localparam int FW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          rx_i;
    logic [FW-1:0] data_i;
    logic          credit_o;
    logic          h_o;
    logic          ack_h_i;
    logic          data_av_o;
    logic [FW-1:0] data_o;
    logic          ack_i;
    logic          sender_o;

    int total = 0;
    int bad   = 0;

    hermes_input_buffer #(
        .FLIT_SIZE  (FW),
        .BUFFER_SIZE(4)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rx_i     (rx_i),
        .data_i   (data_i),
        .credit_o (credit_o),
        .h_o      (h_o),
        .ack_h_i  (ack_h_i),
        .data_av_o(data_av_o),
        .data_o   (data_o),
        .ack_i    (ack_i),
        .sender_o (sender_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [FW-1:0] d);
        rx_i   = 1'b1;
        data_i = d;
        tick();
    endtask

    initial begin
        rst_i = 1'b1; rx_i = 1'b0; data_i = '0; ack_h_i = 1'b0; ack_i = 1'b0;
        tick();
        rst_i = 1'b0;
        chk("rst_credit", credit_o, 1);
        chk("rst_h", h_o, 0);
        chk("rst_dav", data_av_o, 0);
        chk("rst_sender", sender_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_count", dut.count_q, 0);

        // ack_h_i while idle and empty has no effect
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0;
        chk("idle_ackh_h", h_o, 0);
        chk("idle_ackh_dav", data_av_o, 0);

        // Basic packet, ack_i held high throughout
        ack_i = 1'b1;
        put(16'h0011);
        chk("bp_fwft", data_o, 16'h0011);
        chk("bp_h_idle", h_o, 0);
        put(16'h0002);
        chk("bp_h_req", h_o, 1);
        chk("bp_dav_req", data_av_o, 0);
        put(16'hAAAA);
        chk("bp_count3", dut.count_q, 3);
        ack_h_i = 1'b1;
        put(16'hBBBB);
        rx_i = 1'b0; ack_h_i = 1'b0;
        chk("bp_count4", dut.count_q, 4);
        chk("bp_hdr_dav", data_av_o, 1);
        chk("bp_hdr_h", h_o, 0);
        chk("bp_hdr_sender", sender_o, 1);
        chk("bp_d0", data_o, 16'h0011);
        tick();
        chk("bp_d1", data_o, 16'h0002);
        tick();
        chk("bp_d2", data_o, 16'hAAAA);
        tick();
        chk("bp_d3", data_o, 16'hBBBB);
        chk("bp_sender_last", sender_o, 1);
        tick();
        chk("bp_sender_end", sender_o, 0);
        chk("bp_dav_end", data_av_o, 0);
        chk("bp_data_end", data_o, 0);
        chk("bp_count_end", dut.count_q, 0);
        tick();
        chk("bp_idle_h", h_o, 0);
        ack_i = 1'b0;

        // Full buffer: fifth flit dropped
        put(16'h0044);
        put(16'h0002);
        put(16'h0C01);
        chk("full_credit3", credit_o, 1);
        put(16'h0C02);
        chk("full_credit4", credit_o, 0);
        put(16'h0C03);
        rx_i = 1'b0;
        chk("full_count", dut.count_q, 4);
        chk("full_h", h_o, 1);
        chk("full_credit5", credit_o, 0);
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0; ack_i = 1'b1;
        chk("full_hdr", data_o, 16'h0044);
        tick();
        chk("full_credit_pop", credit_o, 1);
        chk("full_size", data_o, 16'h0002);
        tick();
        chk("full_p0", data_o, 16'h0C01);
        tick();
        chk("full_p1", data_o, 16'h0C02);
        tick();
        chk("full_drop", data_o, 0);
        chk("full_empty", dut.count_q, 0);
        chk("full_sender_end", sender_o, 0);
        ack_i = 1'b0;

        // Zero-size packet followed by another header
        put(16'h0022);
        put(16'h0000);
        put(16'h0033);
        rx_i = 1'b0;
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0; ack_i = 1'b1;
        chk("zs_hdr", data_o, 16'h0022);
        tick();
        chk("zs_size", data_o, 16'h0000);
        chk("zs_size_dav", data_av_o, 1);
        tick();
        chk("zs_sender_end", sender_o, 0);
        chk("zs_dav_idle", data_av_o, 0);
        chk("zs_next_head", data_o, 16'h0033);
        chk("zs_h_idle", h_o, 0);
        tick();
        chk("zs_h_next", h_o, 1);
        chk("zs_count1", dut.count_q, 1);
        ack_i = 1'b0;

        // Concurrent read/write in payload (0x0033 is the header)
        put(16'h0005);
        put(16'h0D01);
        put(16'h0D02);
        rx_i = 1'b0;
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0; ack_i = 1'b1;
        tick();
        tick();
        chk("cc_start_count", dut.count_q, 2);
        chk("cc_start_data", data_o, 16'h0D01);
        put(16'h0D03);
        chk("cc_count_a", dut.count_q, 2);
        chk("cc_credit_a", credit_o, 1);
        chk("cc_data_a", data_o, 16'h0D02);
        put(16'h0D04);
        chk("cc_count_b", dut.count_q, 2);
        chk("cc_data_b", data_o, 16'h0D03);
        put(16'h0D05);
        rx_i = 1'b0;
        chk("cc_count_c", dut.count_q, 2);
        chk("cc_credit_c", credit_o, 1);
        chk("cc_data_c", data_o, 16'h0D04);
        tick();
        chk("cc_data_d", data_o, 16'h0D05);
        chk("cc_sender_d", sender_o, 1);
        tick();
        chk("cc_sender_end", sender_o, 0);
        chk("cc_count_end", dut.count_q, 0);
        ack_i = 1'b0;

        // Reset after the first of three payload flits
        put(16'h0055);
        put(16'h0003);
        put(16'h0E01);
        put(16'h0E02);
        rx_i = 1'b0;
        ack_h_i = 1'b1;
        tick();
        ack_h_i = 1'b0; ack_i = 1'b1;
        tick();
        tick();
        chk("mr_p0", data_o, 16'h0E01);
        tick();
        chk("mr_p1", data_o, 16'h0E02);
        rst_i = 1'b1; rx_i = 1'b1; data_i = 16'h0E03;
        tick();
        rst_i = 1'b0; rx_i = 1'b0; ack_i = 1'b0;
        chk("mr_count", dut.count_q, 0);
        chk("mr_sender", sender_o, 0);
        chk("mr_dav", data_av_o, 0);
        chk("mr_credit", credit_o, 1);
        chk("mr_data", data_o, 0);
        tick();
        chk("mr_h", h_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
